// File: rtl/branch_pc_unit_pkg.sv
// Shared encodings and constants for the fetch-PC / branch-resolution slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: BR_* branch/jump class encodings, reset fetch address,
// PC increment, link offset and the conditional-branch target helper.
package branch_pc_unit_pkg;

    // Branch/jump class carried by the decoder into D.
    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4,
        BR_BLTZ = 4'd5,
        BR_BGEZ = 4'd6,
        BR_J    = 4'd7,
        BR_JAL  = 4'd8,
        BR_JR   = 4'd9,
        BR_JALR = 4'd10
    } br_op_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_INC           = 32'd4;
    // Link skips the branch and its delay slot.
    localparam logic [31:0] LINK_OFS         = 32'd8;

    // PC-relative target: offset is relative to the delay-slot address.
    function automatic logic [31:0] rel_target(input logic [31:0] pc,
                                               input logic [15:0] imm16);
        return pc + PC_INC + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/branch_pc_unit_npc_calc.sv
// Next-fetch-address selection: resolves taken/target for the D-stage branch.
// Latency: purely combinational.
// Backpressure: none; stall handling lives in the parent registers.
//
// Ports: br_op/imm16/index26/rs_data and cmp_* flags from D; pc_f, pc_d,
// valid_d from the parent registers; outputs taken, next_pc.
module npc_calc
    import branch_pc_unit_pkg::*;
(
    input  logic [3:0]  br_op,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] rs_data,
    input  logic        cmp_eq,
    input  logic        cmp_blez,
    input  logic        cmp_bgez,
    input  logic        cmp_bgtz,
    input  logic        cmp_bltz,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic        valid_d,
    output logic        taken,
    output logic [31:0] next_pc
);

    logic        cond;
    logic [31:0] target;

    always_comb begin
        cond   = 1'b0;
        target = rel_target(pc_d, imm16);
        case (br_op)
            BR_BEQ:  cond = cmp_eq;
            BR_BNE:  cond = !cmp_eq;
            BR_BLEZ: cond = cmp_blez;
            BR_BGTZ: cond = cmp_bgtz;
            BR_BLTZ: cond = cmp_bltz;
            BR_BGEZ: cond = cmp_bgez;
            BR_J, BR_JAL: begin
                cond   = 1'b1;
                target = {pc_d[31:28], index26, 2'b00};
            end
            BR_JR, BR_JALR: begin
                cond   = 1'b1;
                // Register targets pass through unaligned on purpose.
                target = rs_data;
            end
            // BR_NONE and unused codes never redirect.
            default: cond = 1'b0;
        endcase
    end

    // The post-reset bubble in D carries stale decode; never let it redirect.
    assign taken   = valid_d & cond;
    assign next_pc = taken ? target : (pc_f + PC_INC);

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC and F->D PC pipeline register with one-delay-slot branch redirect.
// Latency: taken branch in D at cycle n -> target in pc_f at n+1, in D at n+2.
// Backpressure: stall freezes pc_f/pc_d/valid_d; decision re-evaluated each stalled cycle.
//
// Ports: clk, reset (sync, active-high, highest priority), stall;
// D-stage br_op_d/imm16_d/index26_d/rs_data_d and cmp_* flags in;
// pc_f, pc_d, valid_d, taken_d (combinational), link_d out.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [3:0]  br_op_d,
    input  logic [15:0] imm16_d,
    input  logic [25:0] index26_d,
    input  logic [31:0] rs_data_d,
    input  logic        cmp_eq,
    input  logic        cmp_blez,
    input  logic        cmp_bgez,
    input  logic        cmp_bgtz,
    input  logic        cmp_bltz,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        taken_d,
    output logic [31:0] link_d
);

    logic [31:0] next_pc;

    npc_calc u_npc_calc (
        .br_op    (br_op_d),
        .imm16    (imm16_d),
        .index26  (index26_d),
        .rs_data  (rs_data_d),
        .cmp_eq   (cmp_eq),
        .cmp_blez (cmp_blez),
        .cmp_bgez (cmp_bgez),
        .cmp_bgtz (cmp_bgtz),
        .cmp_bltz (cmp_bltz),
        .pc_f     (pc_f),
        .pc_d     (pc_d),
        .valid_d  (valid_d),
        .taken    (taken_d),
        .next_pc  (next_pc)
    );

    // Reset discards any pending redirect; stall simply holds, so only the
    // decision present in the first unstalled cycle is ever committed.
    // The delay-slot instruction always advances into D: no flush path.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f    <= RESET_PC;
            pc_d    <= 32'h0;
            valid_d <= 1'b0;
        end else if (!stall) begin
            pc_f    <= next_pc;
            pc_d    <= pc_f;
            valid_d <= 1'b1;
        end
    end

    assign link_d = pc_d + LINK_OFS;

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Owns the fetch PC and the F→D PC pipeline register, and consumes the D-stage comparator's branch flags to choose the next fetch address. It handles all branches and jumps with a one-instruction delay slot. It sits between the instruction memory address port, the D-stage decoder and the D-stage comparator, and is the receiving end of the comparator's flag interface. PC updates are gated by the hazard unit's stall.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; takes priority over every other input.
- stall  in  1  hazard-unit stall; when high, freeze pc_f, pc_d and valid_d.
- br_op_d  in  4  D-stage branch/jump class, encoded as BR_* (see Structure).
- imm16_d  in  16  D-stage branch offset.
- index26_d  in  26  D-stage jump index.
- rs_data_d  in  32  forwarded rs value, used as the jr/jalr target.
- cmp_eq  in  1  comparator flag: rs == rt.
- cmp_blez  in  1  comparator flag: rs <= 0 (signed).
- cmp_bgez  in  1  comparator flag: rs >= 0.
- cmp_bgtz  in  1  comparator flag: rs > 0.
- cmp_bltz  in  1  comparator flag: rs < 0.
- pc_f  out  32  current fetch address.
- pc_d  out  32  PC of the instruction in D.
- valid_d  out  1  D holds a real instruction (not the post-reset bubble).
- taken_d  out  1  combinational: D-stage branch/jump redirects fetch.
- link_d  out  32  pc_d + 8, written by jal/jalr.

## Operation
- taken_d is asserted only when valid_d is 1, according to br_op_d:
  - BR_NONE: 0.
  - BEQ: cmp_eq. BNE: !cmp_eq.
  - BLEZ: cmp_blez. BGTZ: cmp_bgtz. BLTZ: cmp_bltz. BGEZ: cmp_bgez.
  - J, JAL, JR, JALR: 1.
  - Undefined codes are treated as BR_NONE.
- Target address, all arithmetic modulo 2^32:
  - Conditional branches: pc_d + 4 + (sign_extend(imm16_d) << 2).
  - J/JAL: {pc_d[31:28], index26_d, 2'b00}.
  - JR/JALR: rs_data_d, passed through unmodified (no alignment check).
- Next PC: target if taken_d is 1, otherwise pc_f + 4. Wrap past 32'hFFFF_FFFC to 0 is permitted.
- Delay slot: the instruction in F when the branch is in D always proceeds into D. No flush is ever generated.
- link_d = pc_d + 8, valid whenever valid_d is 1.

## Timing
- Reset: on the next edge pc_f = RESET_PC, pc_d = 32'h0, valid_d = 0. Therefore taken_d = 0 and link_d = 32'h8 during reset.
- Normal edge (reset = 0, stall = 0):
  - pc_f ← next PC.
  - pc_d ← pc_f.
  - valid_d ← 1.
- Stall edge (stall = 1): pc_f, pc_d and valid_d hold. The branch decision is re-evaluated every stalled cycle from the current forwarded operands and flags. Only the decision present in the first unstalled cycle takes effect.
- Reset asserted with stall high, or mid-branch: reset wins and any pending redirect is discarded.
- Latency:
  - A taken branch in D at cycle n puts the target in pc_f at cycle n+1.
  - The delay-slot instruction is in D at n+1.
  - The target instruction reaches D at n+2.
- taken_d and the target are purely combinational from the D-stage inputs and registered state. No registered output depends on stall except through hold.

## Structure
- Shared package / header holds:
  - BR_* encodings: BR_NONE = 0, BEQ = 1, BNE = 2, BLEZ = 3, BGTZ = 4, BLTZ = 5, BGEZ = 6, J = 7, JAL = 8, JR = 9, JALR = 10.
  - RESET_PC default.
  - The PC increment constant (4).
- One natural sub-module, npc_calc: combinational target and taken_d logic. The parent keeps the pc_f, pc_d and valid_d registers and the stall/reset muxing.

## Test plan
- Reset then 3 free-running cycles:
  - pc_f = 3000, 3004, 3008, 300C.
  - valid_d is 0 in the first cycle after reset, then 1.
  - pc_d trails pc_f by one cycle.
- BEQ at pc_d = 3010, imm16 = 16'h0003, cmp_eq = 1:
  - taken_d = 1.
  - The next pc_f = 3020.
  - The delay-slot PC 3014 appears in pc_d.
- BNE at pc_d = 3010, imm16 = 16'hFFFE, cmp_eq = 1: not taken, so pc_f → pc_f + 4.
- Repeat with cmp_eq = 0: pc_f → 300C (backward branch).
- JAL at pc_d = 3040, index26 = 26'h0000C10: pc_f → 00003040 and link_d = 3048.
- JR with stall held 2 cycles:
  - rs_data_d changes from 0 to 00003100 during the stall.
  - pc_f and pc_d hold throughout the stall.
  - After stall drops, pc_f = 00003100.
- Reset asserted while stall = 1 and a taken BGTZ is in D:
  - Next edge: pc_f = 3000, valid_d = 0.
  - No redirect occurs.
